// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl -- run/drain/done sequencer for a 5-stage CPU.
//
// Starts the CPU on request. Execution stops on a halt request or when a
// cycle limit is reached. The controller then keeps the pipeline enabled
// for DRAIN_CYCLES more cycles so that it empties, and parks in DONE until
// the next start or a clear. The host is granted the memory ports only
// while the CPU is stopped (IDLE or DONE).
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | CPU stopped; host may own memory; wait for start
//  RUN   | CPU enabled; cycle_cnt counts; exit on halt_req or cycle limit
//  DRAIN | CPU still enabled for DRAIN_CYCLES cycles to empty pipeline
//  DONE  | CPU stopped; cycle_cnt/timeout hold results; wait start/clear
//
// Ports
//   clk         main clock, rising edge
//   arst_n      asynchronous active-low reset
//   start       begin execution (level sampled, ignored while ext_req=1)
//   halt_req    stop request, honoured in RUN only
//   abort       unconditional return to IDLE, highest priority
//   clear       leave DONE for IDLE
//   max_cycles  RUN cycle limit, 0 = unlimited, sampled on RUN entry
//   ext_req     host requests the memory ports
//   enable      pipeline/PC enable (RUN or DRAIN)
//   ext_grant   host may drive memory ports
//   busy        RUN or DRAIN
//   done        in DONE
//   timeout     sticky, last RUN ended on the cycle limit
//   cycle_cnt   RUN cycles of the current/last run, saturating
//   state       IDLE=0 RUN=1 DRAIN=2 DONE=3

module cpu_run_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             abort,
    input  logic             clear,
    input  logic [CNT_W-1:0] max_cycles,
    input  logic             ext_req,
    output logic             enable,
    output logic             ext_grant,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int               DW         = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             timeout_q, timeout_d;
    logic             ext_grant_q, ext_grant_d;
    logic             limit_hit;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            max_q       <= '0;
            drain_q     <= '0;
            timeout_q   <= 1'b0;
            ext_grant_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            drain_q     <= drain_d;
            timeout_q   <= timeout_d;
            ext_grant_q <= ext_grant_d;
        end
    end

    // Last RUN cycle is the one where the count is one below the limit; the
    // increment in that same cycle makes cycle_cnt land exactly on the limit.
    assign limit_hit = (max_q != '0) && (cnt_q == (max_q - CNT_W'(1)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        drain_d     = drain_q;
        timeout_d   = timeout_q;
        ext_grant_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !ext_req) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    max_d     = max_cycles;
                end else if (clear && (state_q == ST_DONE)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (limit_hit) begin
                    timeout_d = 1'b1;
                end
                if (halt_req || limit_hit) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q <= DW'(1)) begin
                    state_d = ST_DONE;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d   = ST_IDLE;
            cnt_d     = cnt_q;
            timeout_d = timeout_q;
            max_d     = max_q;
            drain_d   = '0;
        end

        // Grant is registered against the next state, so it can only be high
        // while the registered state is IDLE or DONE, never alongside enable.
        ext_grant_d = ext_req && ((state_d == ST_IDLE) || (state_d == ST_DONE));
    end

    assign enable    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign busy      = enable;
    assign done      = (state_q == ST_DONE);
    assign timeout   = timeout_q;
    assign cycle_cnt = cnt_q;
    assign ext_grant = ext_grant_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        start = 1'b0, halt_req = 1'b0, abort = 1'b0, clear = 1'b0, ext_req = 1'b0;
    logic [31:0] max_cycles = '0;
    logic        enable, ext_grant, busy, done, timeout;
    logic [31:0] cycle_cnt;
    logic [1:0]  state;

    logic        start4 = 1'b0, halt4 = 1'b0, clear4 = 1'b0;
    logic [3:0]  max4 = '0;
    logic        enable4, ext_grant4, busy4, done4, timeout4;
    logic [3:0]  cycle_cnt4;
    logic [1:0]  state4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl dut (
        .clk(clk), .arst_n(arst_n), .start(start), .halt_req(halt_req),
        .abort(abort), .clear(clear), .max_cycles(max_cycles), .ext_req(ext_req),
        .enable(enable), .ext_grant(ext_grant), .busy(busy), .done(done),
        .timeout(timeout), .cycle_cnt(cycle_cnt), .state(state)
    );

    cpu_run_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .arst_n(arst_n), .start(start4), .halt_req(halt4),
        .abort(abort), .clear(clear4), .max_cycles(max4), .ext_req(ext_req),
        .enable(enable4), .ext_grant(ext_grant4), .busy(busy4), .done(done4),
        .timeout(timeout4), .cycle_cnt(cycle_cnt4), .state(state4)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int en_cnt;
        int d;
        int r;

        // reset, asynchronous
        #2 arst_n = 1'b0;
        #1;
        check_val("rst_state", state, 0);
        check_val("rst_enable", enable, 0);
        check_val("rst_grant", ext_grant, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_cnt", cycle_cnt, 0);
        step();
        step();
        arst_n = 1'b1;
        step();

        // cycle limit of 10: 10 RUN + 4 DRAIN enabled cycles
        max_cycles = 32'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("lim_run_entry", state, 1);
        check_val("lim_cnt0", cycle_cnt, 0);
        en_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (enable) en_cnt++;
            step();
        end
        check_val("lim_reached_done", done, 1);
        check_val("lim_enable_cycles", en_cnt, 14);
        check_val("lim_cnt", cycle_cnt, 10);
        check_val("lim_timeout", timeout, 1);
        check_val("lim_state", state, 3);

        // clear to IDLE, results hold
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_val("clr_state", state, 0);
        check_val("clr_cnt_hold", cycle_cnt, 10);

        // unlimited run, halt in the 7th RUN cycle
        max_cycles = 32'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("halt_timeout_cleared", timeout, 0);
        for (int i = 0; i < 6; i++) step();
        check_val("halt_cnt_before", cycle_cnt, 6);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check_val("halt_drain_state", state, 2);
        check_val("halt_cnt", cycle_cnt, 7);
        d = 0;
        while (state == 2'd2 && d < 20) begin
            d++;
            step();
        end
        check_val("halt_drain_len", d, 4);
        check_val("halt_done", done, 1);
        check_val("halt_timeout", timeout, 0);
        check_val("halt_cnt_done", cycle_cnt, 7);

        // host priority in IDLE
        clear = 1'b1;
        step();
        clear = 1'b0;
        ext_req = 1'b1;
        start = 1'b1;
        step();
        check_val("ext_idle_grant", ext_grant, 1);
        check_val("ext_idle_enable", enable, 0);
        step();
        check_val("ext_idle_state", state, 0);
        ext_req = 1'b0;
        step();
        start = 1'b0;
        check_val("ext_drop_state", state, 1);
        check_val("ext_drop_grant", ext_grant, 0);
        check_val("ext_drop_enable", enable, 1);

        // ext_req raised during RUN waits for DONE
        ext_req = 1'b1;
        step();
        step();
        check_val("ext_run_grant", ext_grant, 0);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            check_val("ext_no_grant_busy", ext_grant, 0);
            step();
        end
        check_val("ext_done_state", state, 3);
        check_val("ext_done_grant", ext_grant, 1);
        check_val("ext_done_enable", enable, 0);
        ext_req = 1'b0;
        step();
        check_val("ext_release", ext_grant, 0);

        // abort in the 2nd DRAIN cycle
        start = 1'b1;
        step();
        start = 1'b0;
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        step();
        check_val("abort_in_drain", state, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("abort_state", state, 0);
        check_val("abort_enable", enable, 0);
        check_val("abort_cnt_hold", cycle_cnt, 1);

        // limit of 1 together with halt in the same cycle
        max_cycles = 32'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check_val("both_state", state, 2);
        check_val("both_timeout", timeout, 1);
        check_val("both_cnt", cycle_cnt, 1);
        for (int i = 0; i < 10; i++) begin
            if (done) break;
            step();
        end
        check_val("both_done", done, 1);

        // limit sampled at RUN entry only
        max_cycles = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        max_cycles = 32'd0;
        r = 0;
        while (state == 2'd1 && r < 50) begin
            r++;
            step();
        end
        check_val("smp_run_cycles", r, 3);
        for (int i = 0; i < 10; i++) begin
            if (done) break;
            step();
        end
        check_val("smp_cnt", cycle_cnt, 3);
        check_val("smp_timeout", timeout, 1);

        // async reset mid-RUN
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check_val("ares_cnt_before", cycle_cnt, 3);
        #2 arst_n = 1'b0;
        #1;
        check_val("ares_enable", enable, 0);
        check_val("ares_cnt", cycle_cnt, 0);
        check_val("ares_state", state, 0);
        check_val("ares_timeout", timeout, 0);
        step();
        arst_n = 1'b1;
        step();

        // 4-bit counter saturation
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int i = 0; i < 19; i++) step();
        check_val("sat_run_state", state4, 1);
        check_val("sat_cnt_run", cycle_cnt4, 15);
        halt4 = 1'b1;
        step();
        halt4 = 1'b0;
        check_val("sat_cnt_drain", cycle_cnt4, 15);
        for (int i = 0; i < 10; i++) begin
            if (done4) break;
            step();
        end
        check_val("sat_done", done4, 1);
        check_val("sat_timeout", timeout4, 0);
        start4 = 1'b1;
        clear4 = 1'b1;
        step();
        start4 = 1'b0;
        clear4 = 1'b0;
        check_val("sat_restart_state", state4, 1);
        check_val("sat_restart_cnt", cycle_cnt4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
